// File: rtl/alu_writeback_queue.sv
// Writeback buffer between the ALU and the register-file write port.
// It updates the zero and compare flags, queues register writes and drains them over valid/ready.
module alu_writeback_queue #(
  parameter int unsigned DATA_W    = 72,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic [3:0]                 in_op,
  output logic                       in_stall,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       flag_z,
  output logic                       flag_cmp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam int unsigned STALL_AT_I = (AFULL_LVL >= DEPTH) ? 0 : DEPTH - AFULL_LVL;
  localparam logic [CW-1:0] STALL_AT = CW'(STALL_AT_I);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          is_write, is_cmp, push_req, pop, push_ok, full;

  always_comb begin
    is_write = in_valid && (in_op <= 4'd4);
    is_cmp   = in_valid && (in_op >= 4'd5) && (in_op <= 4'd7);
    push_req = is_write && (in_rd != '0);
    full     = (count == FULL_CNT);
    pop      = wb_valid && wb_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    push_ok  = push_req && (!full || pop);
  end

  assign wb_valid = (count != '0);
  assign {wb_addr, wb_data} = mem[rd_ptr];
  assign in_stall = (count >= STALL_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      flag_z       <= 1'b0;
      flag_cmp     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {in_rd, in_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push_req && full && !pop) overflow_err <= 1'b1;
      if (is_write) flag_z <= (in_data == '0);
      if (is_cmp)   flag_cmp <= in_data[0];
    end
  end

endmodule

// File: tb/tb_alu_writeback_queue.sv
// Scoreboard bench for alu_writeback_queue: expected writes are queued at issue
// and compared against the head whenever a pop is taken.
module tb_alu_writeback_queue;
  localparam int DW = 72;
  localparam int AW = 5;

  logic          clk, rst_n;
  logic          in_valid, wb_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_rd;
  logic [3:0]    in_op;
  logic          in_stall, wb_valid, flag_z, flag_cmp, overflow_err;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [2:0]    count;

  logic [AW+DW-1:0] sb[$];
  int mcount = 0;
  int vecs = 0;
  int errs = 0;

  alu_writeback_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .AFULL_LVL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_rd(in_rd),
    .in_op(in_op), .in_stall(in_stall), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .flag_z(flag_z), .flag_cmp(flag_cmp),
    .count(count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [DW-1:0] d);
    in_valid = v; in_op = op; in_rd = rd; in_data = d;
    if (v && op <= 4'd4 && rd != '0) begin
      if (mcount < 4) begin sb.push_back({rd, d}); mcount++; end
      else if (wb_ready && mcount == 4) sb.push_back({rd, d});
    end
  endtask

  task automatic test_reset();
    #12;
    vecs++;
    if (wb_valid !== 1'b0 || count !== 3'd0 || flag_z !== 1'b0 || flag_cmp !== 1'b0 ||
        overflow_err !== 1'b0 || in_stall !== 1'b0 || wb_addr !== '0 || wb_data !== '0) begin
      errs++;
      $display("FAIL reset: got v=%b cnt=%0d z=%b c=%b ov=%b st=%b a=%h d=%h, want all zero",
               wb_valid, count, flag_z, flag_cmp, overflow_err, in_stall, wb_addr, wb_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [AW+DW-1:0] e;
    wb_ready = 1'b1;
    drive(1'b1, 4'd0, 5'd3, 72'h2);
    tick();
    drive(1'b0, 4'd0, 5'd0, '0);
    e = sb.pop_front();
    vecs++;
    if (wb_valid !== 1'b1 || {wb_addr, wb_data} !== e || flag_z !== 1'b0) begin
      errs++;
      $display("FAIL basic_out: got v=%b a=%h d=%h z=%b, want v=1 a=%h d=%h z=0",
               wb_valid, wb_addr, wb_data, flag_z, e[AW+DW-1:DW], e[DW-1:0]);
    end
    tick(); mcount--;
    vecs++;
    if (wb_valid !== 1'b0 || count !== 3'd0) begin
      errs++;
      $display("FAIL basic_drain: got v=%b cnt=%0d, want v=0 cnt=0", wb_valid, count);
    end
  endtask

  task automatic drain_checked(input string nm, input int n);
    logic [AW+DW-1:0] e;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wb_ready = 1'b0;
      tick();
      e = sb[0];
      vecs++;
      if (wb_valid !== 1'b1 || {wb_addr, wb_data} !== e) begin
        errs++;
        $display("FAIL %s_stall%0d: got v=%b a=%h d=%h, want v=1 a=%h d=%h", nm, i,
                 wb_valid, wb_addr, wb_data, e[AW+DW-1:DW], e[DW-1:0]);
      end
      wb_ready = 1'b1;
      #1;
      e = sb.pop_front();
      vecs++;
      if (wb_valid !== 1'b1 || {wb_addr, wb_data} !== e) begin
        errs++;
        $display("FAIL %s_pop%0d: got v=%b a=%h d=%h, want v=1 a=%h d=%h", nm, i,
                 wb_valid, wb_addr, wb_data, e[AW+DW-1:DW], e[DW-1:0]);
      end
      tick(); mcount--;
    end
    wb_ready = 1'b0;
    vecs++;
    if (count !== 3'(mcount)) begin
      errs++;
      $display("FAIL %s_count: got %0d want %0d", nm, count, mcount);
    end
  endtask

  task automatic test_passthrough();
    logic [AW+DW-1:0] e;
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'd0, 5'(i), 72'(32 + i));
      tick();
    end
    vecs++;
    if (count !== 3'd4) begin
      errs++; $display("FAIL pt_fill: count got %0d want 4", count);
    end
    wb_ready = 1'b1;
    e = sb.pop_front();
    drive(1'b1, 4'd2, 5'd7, 72'h99);
    vecs++;
    if ({wb_addr, wb_data} !== e) begin
      errs++; $display("FAIL pt_head: got a=%h d=%h want a=%h d=%h",
                       wb_addr, wb_data, e[AW+DW-1:DW], e[DW-1:0]);
    end
    tick();
    vecs++;
    if (count !== 3'd4 || overflow_err !== 1'b0) begin
      errs++; $display("FAIL pt_count: got cnt=%0d ov=%b want cnt=4 ov=0", count, overflow_err);
    end
    drain_checked("pt", 4);
  endtask

  task automatic test_flags();
    wb_ready = 1'b0;
    drive(1'b1, 4'd5, 5'd0, 72'h1); tick();
    vecs++;
    if (flag_cmp !== 1'b1) begin errs++; $display("FAIL cmp_eq: got %b want 1", flag_cmp); end
    drive(1'b1, 4'd7, 5'd4, 72'h0); tick();
    vecs++;
    if (flag_cmp !== 1'b0 || count !== 3'd0) begin
      errs++; $display("FAIL cmp_lt: got cmp=%b cnt=%0d want cmp=0 cnt=0", flag_cmp, count);
    end
    drive(1'b1, 4'd1, 5'd2, 72'h0); tick();
    vecs++;
    if (flag_z !== 1'b1 || count !== 3'd1) begin
      errs++; $display("FAIL sub_zero: got z=%b cnt=%0d want z=1 cnt=1", flag_z, count);
    end
    drive(1'b1, 4'd4, 5'd0, 72'h8); tick();
    vecs++;
    if (flag_z !== 1'b0 || count !== 3'd1) begin
      errs++; $display("FAIL shr_r0: got z=%b cnt=%0d want z=0 cnt=1", flag_z, count);
    end
    drive(1'b1, 4'd9, 5'd5, 72'h0); tick();
    drive(1'b1, 4'd12, 5'd6, 72'h1); tick();
    vecs++;
    if (flag_z !== 1'b0 || flag_cmp !== 1'b0 || count !== 3'd1 || overflow_err !== 1'b0) begin
      errs++; $display("FAIL bad_op: got z=%b cmp=%b cnt=%0d ov=%b want 0 0 1 0",
                       flag_z, flag_cmp, count, overflow_err);
    end
    drain_checked("flags", 1);
  endtask

  task automatic test_wrap();
    logic [95:0] r;
    logic [AW+DW-1:0] e;
    wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = {$urandom, $urandom, $urandom};
      drive(1'b1, 4'(i % 5), 5'(i % 31 + 1), r[DW-1:0]);
      tick();
      drive(1'b0, 4'd0, 5'd0, '0);
      e = sb.pop_front();
      vecs++;
      if (wb_valid !== 1'b1 || {wb_addr, wb_data} !== e || count !== 3'd1) begin
        errs++; $display("FAIL wrap%0d: got v=%b cnt=%0d a=%h d=%h want v=1 cnt=1 a=%h d=%h", i,
                         wb_valid, count, wb_addr, wb_data, e[AW+DW-1:DW], e[DW-1:0]);
      end
      tick(); mcount--;
    end
    vecs++;
    if (count !== 3'd0 || wb_valid !== 1'b0) begin
      errs++; $display("FAIL wrap_end: got cnt=%0d v=%b want 0 0", count, wb_valid);
    end
  endtask

  task automatic test_fill_overflow();
    wb_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'd0, 5'(i), 72'(15 + i));
      tick();
      vecs++;
      if (count !== 3'(mcount) || in_stall !== (mcount >= 3) ||
          overflow_err !== (i == 5)) begin
        errs++; $display("FAIL fill%0d: got cnt=%0d st=%b ov=%b want cnt=%0d st=%b ov=%b", i,
                         count, in_stall, overflow_err, mcount, mcount >= 3, i == 5);
      end
    end
    drain_checked("ovf", 4);
    vecs++;
    if (overflow_err !== 1'b1) begin
      errs++; $display("FAIL ovf_sticky: got %b want 1", overflow_err);
    end
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    drive(1'b1, 4'd5, 5'd0, 72'h1); tick();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'd0, 5'(i + 8), 72'h0); tick();
    end
    drive(1'b0, 4'd0, 5'd0, '0);
    vecs++;
    if (count !== 3'd3 || overflow_err !== 1'b1 || flag_z !== 1'b1 || flag_cmp !== 1'b1) begin
      errs++; $display("FAIL ar_pre: got cnt=%0d ov=%b z=%b c=%b want 3 1 1 1",
                       count, overflow_err, flag_z, flag_cmp);
    end
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if (wb_valid !== 1'b0 || count !== 3'd0 || flag_z !== 1'b0 || flag_cmp !== 1'b0 ||
        overflow_err !== 1'b0 || in_stall !== 1'b0) begin
      errs++; $display("FAIL ar_post: got v=%b cnt=%0d z=%b c=%b ov=%b st=%b want all 0",
                       wb_valid, count, flag_z, flag_cmp, overflow_err, in_stall);
    end
    sb.delete();
    mcount = 0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    in_data = '0; in_rd = '0; in_op = '0;
    test_reset();
    test_basic();
    test_passthrough();
    test_flags();
    test_wrap();
    test_fill_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
